// File: rtl/attn_score_accum.sv
// attn_score_accum: sums BEAT_NUM partial spike-product beats into one Q.K score per
// time step and presents each completed score on a valid/ready port. The upstream
// PE cannot stall, so a single holding register decouples it; a completion that
// finds the register occupied is dropped and flagged on a sticky overflow.
module attn_score_accum #(
  parameter int IN_W       = 4,
  parameter int TIME_STEPS = 4,
  parameter int BEAT_NUM   = 8,
  parameter int KEY_NUM    = 64,
  localparam int ACC_W     = IN_W + $clog2(BEAT_NUM),
  localparam int IDX_W     = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
  input  logic                        s_clk,
  input  logic                        s_rst,
  input  logic [IN_W*TIME_STEPS-1:0]  i_Calc_data,
  input  logic                        i_Calc_valid,
  output logic [ACC_W*TIME_STEPS-1:0] o_Score_data,
  output logic [IDX_W-1:0]            o_Score_idx,
  output logic                        o_Score_valid,
  input  logic                        i_Score_ready,
  output logic                        o_Overflow
);

  localparam int CNT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;

  typedef enum logic {StEmpty, StHeld} outState_e;

  outState_e                            stateQ, stateD;
  logic [CNT_W-1:0]                     cntQ;
  logic [IDX_W-1:0]                     kidxQ, kidxD;
  logic [TIME_STEPS-1:0][ACC_W-1:0]     accQ, sumD;
  logic [TIME_STEPS-1:0][ACC_W-1:0]     dataQ;
  logic [IDX_W-1:0]                     idxQ;
  logic                                 ovfQ, ovfD;
  logic                                 firstBeat, lastBeat, complete, outFree, loadOut;

  assign firstBeat = (cntQ == '0);
  assign lastBeat  = (cntQ == CNT_W'(BEAT_NUM - 1));
  assign complete  = i_Calc_valid && lastBeat;
  assign outFree   = (stateQ == StEmpty) || i_Score_ready;

  // Running sum including the current beat; on the final beat this is the score.
  always_comb begin
    sumD = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      if (firstBeat) begin
        sumD[t] = ACC_W'(i_Calc_data[IN_W*t +: IN_W]);
      end else begin
        sumD[t] = accQ[t] + ACC_W'(i_Calc_data[IN_W*t +: IN_W]);
      end
    end
  end

  // Output-slot next state: load on completion when free, drop and flag otherwise.
  always_comb begin
    stateD  = stateQ;
    kidxD   = kidxQ;
    ovfD    = ovfQ;
    loadOut = 1'b0;
    if (complete) begin
      // kidx tracks the key stream even for dropped scores.
      kidxD = (kidxQ == IDX_W'(KEY_NUM - 1)) ? '0 : kidxQ + IDX_W'(1);
      if (outFree) begin
        loadOut = 1'b1;
        stateD  = StHeld;
      end else begin
        ovfD = 1'b1;
      end
    end else if ((stateQ == StHeld) && i_Score_ready) begin
      stateD = StEmpty;
    end
  end

  // Output-slot state register, key counter and sticky overflow.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      stateQ <= StEmpty;
      kidxQ  <= '0;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      kidxQ  <= kidxD;
      ovfQ   <= ovfD;
    end
  end

  // Beat counter and accumulators advance only on valid beats; gaps hold them.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      cntQ <= '0;
      accQ <= '0;
    end else if (i_Calc_valid) begin
      cntQ <= lastBeat ? '0 : cntQ + CNT_W'(1);
      accQ <= sumD;
    end
  end

  // Holding register changes only when a completed score is loaded.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      dataQ <= '0;
      idxQ  <= '0;
    end else if (loadOut) begin
      dataQ <= sumD;
      idxQ  <= kidxQ;
    end
  end

  assign o_Score_data  = dataQ;
  assign o_Score_idx   = idxQ;
  assign o_Score_valid = (stateQ == StHeld);
  assign o_Overflow    = ovfQ;

endmodule

// File: tb/tb_attn_score_accum.sv
// Self-checking bench for attn_score_accum: directed scenarios from the block's
// behaviour list plus a randomized run against a group-sum reference model.
module tb_attn_score_accum;

  localparam int IN_W  = 4;
  localparam int TS    = 4;
  localparam int BEATS = 8;
  localparam int KEYS  = 64;
  localparam int ACC_W = IN_W + $clog2(BEATS);
  localparam int IDX_W = $clog2(KEYS);
  localparam int DW    = IN_W * TS;
  localparam int OW    = ACC_W * TS;

  logic             s_clk = 1'b0;
  logic             s_rst;
  logic [DW-1:0]    i_Calc_data;
  logic             i_Calc_valid;
  logic [OW-1:0]    o_Score_data;
  logic [IDX_W-1:0] o_Score_idx;
  logic             o_Score_valid;
  logic             i_Score_ready;
  logic             o_Overflow;

  attn_score_accum #(
    .IN_W(IN_W), .TIME_STEPS(TS), .BEAT_NUM(BEATS), .KEY_NUM(KEYS)
  ) dut (
    .s_clk        (s_clk),
    .s_rst        (s_rst),
    .i_Calc_data  (i_Calc_data),
    .i_Calc_valid (i_Calc_valid),
    .o_Score_data (o_Score_data),
    .o_Score_idx  (o_Score_idx),
    .o_Score_valid(o_Score_valid),
    .i_Score_ready(i_Score_ready),
    .o_Overflow   (o_Overflow)
  );

  always #5 s_clk = ~s_clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: beats collected per group, score = plain sum of the group.
  int mBeats;
  int mSum [TS];
  int mKidx;
  bit mValid;
  int mData [TS];
  int mIdx;
  bit mOvf;

  function automatic logic [DW-1:0] fillIn(input int v);
    logic [DW-1:0] r;
    for (int t = 0; t < TS; t++) r[IN_W*t +: IN_W] = IN_W'(v);
    return r;
  endfunction

  function automatic logic [OW-1:0] fillOut(input int v);
    logic [OW-1:0] r;
    for (int t = 0; t < TS; t++) r[ACC_W*t +: ACC_W] = ACC_W'(v);
    return r;
  endfunction

  function automatic logic [OW-1:0] modelData();
    logic [OW-1:0] r;
    for (int t = 0; t < TS; t++) r[ACC_W*t +: ACC_W] = ACC_W'(mData[t]);
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model, return #1 after the edge.
  task automatic drive(input logic rst, input logic v, input logic [DW-1:0] d,
                       input logic rdy);
    bit freeSlot;
    s_rst = rst; i_Calc_valid = v; i_Calc_data = d; i_Score_ready = rdy;
    if (rst) begin
      mBeats = 0; mKidx = 0; mValid = 0; mIdx = 0; mOvf = 0;
      for (int t = 0; t < TS; t++) begin mSum[t] = 0; mData[t] = 0; end
    end else begin
      freeSlot = !mValid || rdy;
      if (v) begin
        for (int t = 0; t < TS; t++) begin
          if (mBeats == 0) mSum[t] = 0;
          mSum[t] += int'(d[IN_W*t +: IN_W]);
        end
        mBeats++;
      end
      if (v && mBeats == BEATS) begin
        mBeats = 0;
        if (freeSlot) begin
          for (int t = 0; t < TS; t++) mData[t] = mSum[t];
          mIdx = mKidx; mValid = 1;
        end else begin
          mOvf = 1;
        end
        mKidx = (mKidx + 1) % KEYS;
      end else if (mValid && rdy) begin
        mValid = 0;
      end
    end
    @(posedge s_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, fillIn(9), 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0);
    nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
      $display("FAIL reset_valid: got %0b want 0", o_Score_valid); end
    nChecks++; if (o_Score_data !== '0) begin nFails++;
      $display("FAIL reset_data: got %h want 0", o_Score_data); end
    nChecks++; if (o_Score_idx !== '0) begin nFails++;
      $display("FAIL reset_idx: got %0d want 0", o_Score_idx); end
    nChecks++; if (o_Overflow !== 1'b0) begin nFails++;
      $display("FAIL reset_overflow: got %0b want 0", o_Overflow); end
  endtask

  task automatic test_defaults();
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int b = 0; b < BEATS; b++) begin
      drive(1'b0, 1'b1, fillIn(3), 1'b1);
      if (b < BEATS - 1) begin
        nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
          $display("FAIL defaults_early_valid: beat %0d got %0b want 0", b, o_Score_valid); end
      end
    end
    nChecks++; if (o_Score_valid !== 1'b1) begin nFails++;
      $display("FAIL defaults_valid: got %0b want 1", o_Score_valid); end
    nChecks++; if (o_Score_data !== fillOut(24)) begin nFails++;
      $display("FAIL defaults_data: got %h want %h", o_Score_data, fillOut(24)); end
    nChecks++; if (o_Score_idx !== 6'd0) begin nFails++;
      $display("FAIL defaults_idx: got %0d want 0", o_Score_idx); end
    drive(1'b0, 1'b0, '0, 1'b1);
    nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
      $display("FAIL defaults_valid_drop: got %0b want 0", o_Score_valid); end
  endtask

  task automatic test_packing();
    logic [DW-1:0] d;
    logic [OW-1:0] exp;
    d = {4'd15, 4'd0, 4'd2, 4'd1};
    exp = {7'd120, 7'd0, 7'd16, 7'd8};
    for (int b = 0; b < BEATS; b++) drive(1'b0, 1'b1, d, 1'b1);
    nChecks++; if (o_Score_data !== exp) begin nFails++;
      $display("FAIL packing_data: got %h want %h", o_Score_data, exp); end
    nChecks++; if (o_Score_idx !== 6'd1) begin nFails++;
      $display("FAIL packing_idx: got %0d want 1", o_Score_idx); end
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_gapped();
    for (int b = 0; b < BEATS; b++) begin
      drive(1'b0, 1'b1, fillIn(1), 1'b1);
      if (b < BEATS - 1) begin
        nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
          $display("FAIL gapped_early_valid: beat %0d got %0b want 0", b, o_Score_valid); end
        drive(1'b0, 1'b0, fillIn(7), 1'b1);
        nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
          $display("FAIL gapped_idle_valid: gap %0d got %0b want 0", b, o_Score_valid); end
      end
    end
    nChecks++; if (o_Score_valid !== 1'b1 || o_Score_data !== fillOut(8)) begin nFails++;
      $display("FAIL gapped_score: got v=%0b %h want v=1 %h", o_Score_valid, o_Score_data,
               fillOut(8)); end
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int b = 0; b < 2 * BEATS; b++) begin
      drive(1'b0, 1'b1, fillIn(2), 1'b0);
      if (b >= BEATS - 1) begin
        nChecks++;
        if (o_Score_valid !== 1'b1 || o_Score_data !== fillOut(16) || o_Score_idx !== 6'd0)
        begin nFails++;
          $display("FAIL overflow_hold: beat %0d got v=%0b %h idx=%0d want v=1 %h idx=0",
                   b, o_Score_valid, o_Score_data, o_Score_idx, fillOut(16)); end
      end
      if (b == BEATS - 1 || b == 2 * BEATS - 2) begin
        nChecks++; if (o_Overflow !== 1'b0) begin nFails++;
          $display("FAIL overflow_early: beat %0d got %0b want 0", b, o_Overflow); end
      end
    end
    nChecks++; if (o_Overflow !== 1'b1) begin nFails++;
      $display("FAIL overflow_flag: got %0b want 1", o_Overflow); end
    drive(1'b0, 1'b0, '0, 1'b1);
    nChecks++; if (o_Score_valid !== 1'b0) begin nFails++;
      $display("FAIL overflow_transfer: got %0b want 0", o_Score_valid); end
    for (int b = 0; b < BEATS; b++) drive(1'b0, 1'b1, fillIn(5), 1'b1);
    nChecks++;
    if (o_Score_idx !== 6'd2 || o_Score_data !== fillOut(40) || o_Overflow !== 1'b1) begin
      nFails++;
      $display("FAIL overflow_next: got idx=%0d %h ovf=%0b want idx=2 %h ovf=1",
               o_Score_idx, o_Score_data, o_Overflow, fillOut(40)); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int b = 0; b < BEATS; b++) drive(1'b0, 1'b1, fillIn(1), 1'b0);
    for (int b = 0; b < BEATS - 1; b++) drive(1'b0, 1'b1, fillIn(2), 1'b0);
    nChecks++; if (o_Score_data !== fillOut(8) || o_Score_idx !== 6'd0) begin nFails++;
      $display("FAIL simul_held_a: got %h idx=%0d want %h idx=0", o_Score_data,
               o_Score_idx, fillOut(8)); end
    drive(1'b0, 1'b1, fillIn(2), 1'b1);
    nChecks++;
    if (o_Score_valid !== 1'b1 || o_Score_data !== fillOut(16) || o_Score_idx !== 6'd1) begin
      nFails++;
      $display("FAIL simul_load_b: got v=%0b %h idx=%0d want v=1 %h idx=1",
               o_Score_valid, o_Score_data, o_Score_idx, fillOut(16)); end
    nChecks++; if (o_Overflow !== 1'b0) begin nFails++;
      $display("FAIL simul_overflow: got %0b want 0", o_Overflow); end
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_wrap();
    logic [DW-1:0] d;
    for (int b = 0; b < 5; b++) drive(1'b0, 1'b1, fillIn(7), 1'b1);
    drive(1'b1, 1'b1, fillIn(7), 1'b1);
    for (int b = 0; b < BEATS; b++) drive(1'b0, 1'b1, fillIn(1), 1'b1);
    nChecks++;
    if (o_Score_valid !== 1'b1 || o_Score_data !== fillOut(8) || o_Score_idx !== 6'd0) begin
      nFails++;
      $display("FAIL wrap_after_reset: got v=%0b %h idx=%0d want v=1 %h idx=0",
               o_Score_valid, o_Score_data, o_Score_idx, fillOut(8)); end
    for (int g = 0; g < KEYS; g++) begin
      for (int b = 0; b < BEATS; b++) begin
        d = DW'($urandom);
        drive(1'b0, 1'b1, d, 1'b1);
      end
      nChecks++; if (o_Score_idx !== IDX_W'((g + 1) % KEYS)) begin nFails++;
        $display("FAIL wrap_idx: group %0d got %0d want %0d", g, o_Score_idx, (g + 1) % KEYS);
      end
      nChecks++; if (o_Score_data !== modelData()) begin nFails++;
        $display("FAIL wrap_data: group %0d got %h want %h", g, o_Score_data, modelData());
      end
    end
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic r, v, rdy;
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      drive(r, v, DW'($urandom), rdy);
      nChecks++;
      if (o_Score_valid !== mValid || o_Overflow !== mOvf ||
          (mValid && (o_Score_data !== modelData() || o_Score_idx !== IDX_W'(mIdx)))) begin
        nFails++;
        $display("FAIL random: cycle %0d got v=%0b ovf=%0b %h idx=%0d want v=%0b ovf=%0b %h idx=%0d",
                 c, o_Score_valid, o_Overflow, o_Score_data, o_Score_idx,
                 mValid, mOvf, modelData(), mIdx);
      end
    end
  endtask

  initial begin
    s_rst = 1'b1; i_Calc_valid = 1'b0; i_Calc_data = '0; i_Score_ready = 1'b0;
    test_reset();
    test_defaults();
    test_packing();
    test_gapped();
    test_overflow();
    test_simultaneous();
    test_reset_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
